// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the synchronous FIFO family.
// Read-mode encodings and parameter sanity checks live here so every FIFO agrees on them.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int fifoDepth(input int aw);
        return 1 << aw;
    endfunction

    // True when the almost-full/almost-empty thresholds make sense for this depth.
    function automatic bit threshLegal(input int aw, input int af, input int ae);
        int depth;
        depth = fifoDepth(aw);
        return (aw >= 1) && (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Contents are never reset; the controller decides which words are valid.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              wren,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    localparam int DEPTH = fifoDepth(AWIDTH);

    logic [DWIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wren) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with occupancy count, programmable almost flags,
// standard or first-word-fall-through read mode, synchronous flush and sticky error flags.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int AWIDTH    = 4,
    parameter int FWFT      = FIFO_STD,
    parameter int AF_THRESH = 2**AWIDTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wren,
    input  logic [DWIDTH-1:0] din,
    input  logic              rden,
    output logic [DWIDTH-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int             DEPTH     = fifoDepth(AWIDTH);
    localparam int             CW        = AWIDTH + 1;
    localparam logic [CW-1:0]  DEPTH_LVL = CW'(DEPTH);
    localparam logic [CW-1:0]  AF_LVL    = CW'(AF_THRESH);
    localparam logic [CW-1:0]  AE_LVL    = CW'(AE_THRESH);

    generate
        if (!threshLegal(AWIDTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
            $error("sync_fifo_ctrl: AWIDTH must be >= 1, AF_THRESH in 1..DEPTH, AE_THRESH in 0..DEPTH-1");
        end
        if ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT)) begin : g_bad_mode
            $error("sync_fifo_ctrl: FWFT must be FIFO_STD or FIFO_FWFT");
        end
    endgenerate

    logic [CW-1:0]     wptr_q, wptr_d;
    logic [CW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, empty_q, almostFull_q, almostEmpty_q;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wrOk, rdOk;
    logic [DWIDTH-1:0] memRdata;

    // Flush and reset swallow any request in the same cycle, so neither touches storage or pointers.
    always_comb begin
        wrOk        = wren & ~full_q  & ~flush & ~rst;
        rdOk        = rden & ~empty_q & ~flush & ~rst;
        wptr_d      = wptr_q  + {{AWIDTH{1'b0}}, wrOk};
        rptr_d      = rptr_q  + {{AWIDTH{1'b0}}, rdOk};
        count_d     = count_q + {{AWIDTH{1'b0}}, wrOk} - {{AWIDTH{1'b0}}, rdOk};
        overflow_d  = overflow_q  | (wren & full_q);
        underflow_d = underflow_q | (rden & empty_q);
        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    // Flags are registered from the next count so no request input reaches them combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almostFull_q  <= 1'b0;
            almostEmpty_q <= 1'b1;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            full_q        <= (count_d == DEPTH_LVL);
            empty_q       <= (count_d == '0);
            almostFull_q  <= (count_d >= AF_LVL);
            almostEmpty_q <= (count_d <= AE_LVL);
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    fifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk   (clk),
        .wren  (wrOk),
        .waddr (wptr_q[AWIDTH-1:0]),
        .wdata (din),
        .raddr (rptr_q[AWIDTH-1:0]),
        .rdata (memRdata)
    );

    generate
        if (FWFT == FIFO_STD) begin : g_std_dout
            logic [DWIDTH-1:0] dout_q;

            // Standard mode: the head word is captured on an accepted read and held otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rdOk) begin
                    dout_q <= memRdata;
                end
            end

            assign dout = dout_q;
        end else begin : g_fwft_dout
            assign dout = memRdata;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almostFull_q;
    assign almost_empty = almostEmpty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Wrapping binary pointers always differ by exactly the occupancy.
    ptrCountConsistent: assert property (@(posedge clk) disable iff (rst)
        (wptr_q - rptr_q) == count_q);

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl: standard and FWFT instances share directed stimulus,
// a queue-based reference pushes one expected record per cycle and a monitor compares them.
module tb_sync_fifo_ctrl;

    localparam int MDEPTH = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       flush = 1'b0;
    logic       wren  = 1'b0;
    logic       rden  = 1'b0;
    logic [7:0] din   = 8'h00;

    logic [7:0] doutS, doutF;
    logic       fullS, emptyS, afS, aeS, ovfS, udfS;
    logic       fullF, emptyF, afF, aeF, ovfF, udfF;
    logic [2:0] countS, countF;

    typedef struct {
        string      name;
        logic [2:0] count;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       udf;
        logic [7:0] doutStd;
        logic       chkFw;
        logic [7:0] doutFw;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] modelQ[$];
    logic       mOvf      = 1'b0;
    logic       mUdf      = 1'b0;
    logic [7:0] mDoutStd  = 8'h00;
    int         testsRun    = 0;
    int         testsFailed = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(
        .DWIDTH(8), .AWIDTH(2), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)
    ) dutStd (
        .clk(clk), .rst(rst), .flush(flush), .wren(wren), .din(din), .rden(rden),
        .dout(doutS), .full(fullS), .empty(emptyS), .almost_full(afS),
        .almost_empty(aeS), .count(countS), .overflow(ovfS), .underflow(udfS)
    );

    sync_fifo_ctrl #(
        .DWIDTH(8), .AWIDTH(2), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)
    ) dutFw (
        .clk(clk), .rst(rst), .flush(flush), .wren(wren), .din(din), .rden(rden),
        .dout(doutF), .full(fullF), .empty(emptyF), .almost_full(afF),
        .almost_empty(aeF), .count(countF), .overflow(ovfF), .underflow(udfF)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle, advance the reference FIFO across the edge and queue what the DUTs must show.
    task automatic applyStimulus(input string name, input logic r, input logic f,
                                 input logic w, input logic [7:0] d, input logic rd);
        exp_t e;
        bit   wasFull, wasEmpty;
        rst   = r;
        flush = f;
        wren  = w;
        din   = d;
        rden  = rd;
        @(posedge clk);
        if (r) begin
            modelQ.delete();
            mOvf     = 1'b0;
            mUdf     = 1'b0;
            mDoutStd = 8'h00;
        end else if (f) begin
            modelQ.delete();
            mOvf = 1'b0;
            mUdf = 1'b0;
        end else begin
            wasFull  = (modelQ.size() == MDEPTH);
            wasEmpty = (modelQ.size() == 0);
            if (w && wasFull)   mOvf = 1'b1;
            if (rd && wasEmpty) mUdf = 1'b1;
            if (rd && !wasEmpty) mDoutStd = modelQ.pop_front();
            if (w && !wasFull)   modelQ.push_back(d);
        end
        e.name    = name;
        e.count   = 3'(modelQ.size());
        e.full    = (modelQ.size() == MDEPTH);
        e.empty   = (modelQ.size() == 0);
        e.af      = (modelQ.size() >= 3);
        e.ae      = (modelQ.size() <= 1);
        e.ovf     = mOvf;
        e.udf     = mUdf;
        e.doutStd = mDoutStd;
        e.chkFw   = (modelQ.size() != 0);
        e.doutFw  = (modelQ.size() != 0) ? modelQ[0] : 8'h00;
        expQ.push_back(e);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        applyStimulus($sformatf("wr%02h", d), 1'b0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic rd(input string name);
        applyStimulus(name, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic wrRd(input logic [7:0] d);
        applyStimulus($sformatf("wrRd%02h", d), 1'b0, 1'b0, 1'b1, d, 1'b1);
    endtask

    // Monitor: every falling edge with a pending record is one cycle's worth of comparisons.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput({e.name, ":countS"}, 32'(countS), 32'(e.count));
                checkOutput({e.name, ":fullS"},  32'(fullS),  32'(e.full));
                checkOutput({e.name, ":emptyS"}, 32'(emptyS), 32'(e.empty));
                checkOutput({e.name, ":afS"},    32'(afS),    32'(e.af));
                checkOutput({e.name, ":aeS"},    32'(aeS),    32'(e.ae));
                checkOutput({e.name, ":ovfS"},   32'(ovfS),   32'(e.ovf));
                checkOutput({e.name, ":udfS"},   32'(udfS),   32'(e.udf));
                checkOutput({e.name, ":doutS"},  32'(doutS),  32'(e.doutStd));
                checkOutput({e.name, ":countF"}, 32'(countF), 32'(e.count));
                checkOutput({e.name, ":emptyF"}, 32'(emptyF), 32'(e.empty));
                checkOutput({e.name, ":fullF"},  32'(fullF),  32'(e.full));
                checkOutput({e.name, ":ovfF"},   32'(ovfF),   32'(e.ovf));
                checkOutput({e.name, ":udfF"},   32'(udfF),   32'(e.udf));
                if (e.chkFw) begin
                    checkOutput({e.name, ":doutF"}, 32'(doutF), 32'(e.doutFw));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waitCycles;
        applyStimulus("reset", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus("idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Fill to full, then an overflowing write.
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44); wr(8'h55);

        // Drain in standard order, then an underflowing read that must leave dout alone.
        rd("rd1"); rd("rd2"); rd("rd3"); rd("rd4"); rd("rd5");
        @(negedge clk);
        checkOutput("holdAfterUnderflow", 32'(doutS), 32'h44);

        applyStimulus("flushA", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Fall-through: the word is visible right after the writing edge.
        wr(8'hA5);
        @(negedge clk);
        checkOutput("fwftFallThrough", 32'(doutF), 32'hA5);
        checkOutput("fwftNotEmpty", 32'(emptyF), 32'h0);
        rd("rdA5");

        // Simultaneous traffic at mid-level, at full and at empty.
        wr(8'h01); wr(8'h02);
        wrRd(8'h03); wrRd(8'h04); wrRd(8'h05);
        wr(8'h06); wr(8'h07);
        wrRd(8'h08);
        rd("rdAfterFull1"); rd("rdAfterFull2"); rd("rdAfterFull3");
        wrRd(8'h09);

        // Flush at count 3 with a competing write, then a clean write/read round trip.
        wr(8'h0A); wr(8'h0B);
        applyStimulus("flushWr", 1'b0, 1'b1, 1'b1, 8'h99, 1'b0);
        @(negedge clk);
        checkOutput("countAfterFlush", 32'(countS), 32'h0);
        wr(8'h7E);
        rd("rd7E");
        @(negedge clk);
        checkOutput("readback7E", 32'(doutS), 32'h7E);
        applyStimulus("idleEnd", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 8) begin
            @(negedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboardDrain: %0d records left, expected 0", expQ.size());
        end
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
